// File: rtl/if_player_pkg.sv
// Shared types and constants for the IF pulse player and the DDC bench.
package if_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int IF_ADDR_WIDTH = 11;
    localparam int IF_DATA_WIDTH = 12;

    // rom_en to if_valid latency: one ROM read cycle plus one output register.
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/if_pulse_player_timer.sv
// PRI counter and pulse counter: generate the ROM read strobe/address and
// the end-of-pulse / end-of-train / end-of-PRI flags consumed by the FSM.
module if_pri_timer
    import if_player_pkg::*;
#(
    parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int PULSE_LEN  = 1500,
    parameter int PRI_LEN    = 2000,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  play,
    input  logic [CNT_WIDTH-1:0]  num_pulses,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [CNT_WIDTH-1:0]  pulse_idx,
    output logic                  first_addr,
    output logic                  last_addr,
    output logic                  last_pulse,
    output logic                  pri_end
);

    // One extra bit so PULSE_LEN == PRI_LEN == 2**k still fits the compare constants.
    localparam int PW = $clog2(PRI_LEN + 1);
    localparam logic [PW-1:0] PULSE_LIM = PW'(PULSE_LEN);
    localparam logic [PW-1:0] PULSE_END = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0] PRI_END   = PW'(PRI_LEN - 1);

    logic [PW-1:0]         cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0]  pidx_reg, pidx_next;
    logic [CNT_WIDTH-1:0]  npul_reg, npul_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;

    always_comb begin
        cnt_next  = cnt_reg;
        pidx_next = pidx_reg;
        npul_next = npul_reg;
        addr_next = addr_reg;
        if (load) begin
            cnt_next  = '0;
            pidx_next = '0;
            npul_next = num_pulses;
        end else if (advance) begin
            if (pri_end) begin
                cnt_next  = '0;
                pidx_next = pidx_reg + CNT_WIDTH'(1);
            end else begin
                cnt_next = cnt_reg + PW'(1);
            end
        end
        // The address only tracks the count inside the pulse window and holds otherwise.
        if ((load || advance) && (cnt_next < PULSE_LIM))
            addr_next = ADDR_WIDTH'(cnt_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            pidx_reg <= '0;
            npul_reg <= '0;
            addr_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            pidx_reg <= pidx_next;
            npul_reg <= npul_next;
            addr_reg <= addr_next;
        end
    end

    assign rom_en     = play && (cnt_reg < PULSE_LIM);
    assign rom_addr   = addr_reg;
    assign pulse_idx  = pidx_reg;
    assign first_addr = (cnt_reg == '0);
    assign last_addr  = (cnt_reg == PULSE_END);
    assign last_pulse = (pidx_reg == (npul_reg - CNT_WIDTH'(1)));
    assign pri_end    = (cnt_reg == PRI_END);

endmodule

// File: rtl/if_pulse_player.sv
// Replays a stored IF pulse from ROM as a train of N pulses at a fixed PRI,
// with framing, start/abort control and completion status.
module if_pulse_player
    import if_player_pkg::*;
#(
    parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int DATA_WIDTH = IF_DATA_WIDTH,
    parameter int PULSE_LEN  = 1500,
    parameter int PRI_LEN    = 2000,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         num_pulses,
    output logic                         rom_en,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_data,
    output logic signed [DATA_WIDTH-1:0] if_data_out,
    output logic                         if_valid,
    output logic                         pulse_sop,
    output logic                         pulse_eop,
    output logic [CNT_WIDTH-1:0]         pulse_idx,
    output logic                         busy,
    output logic                         done
);

    localparam bit BACK_TO_BACK = (PRI_LEN == PULSE_LEN);

    typedef struct packed {
        logic                 valid;
        logic                 sop;
        logic                 eop;
        logic                 last;
        logic [CNT_WIDTH-1:0] idx;
    } tag_t;

    state_t state_reg, state_next;
    logic   flush_reg, flush_next;
    logic   zero_done_reg;
    logic   load, advance, zero_start, play;
    logic   first_addr, last_addr, last_pulse, pri_end;
    logic [CNT_WIDTH-1:0] timer_idx;
    tag_t   tag_in, tag_pre, tag_out;
    logic signed [DATA_WIDTH-1:0] data_reg;

    if_pri_timer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PULSE_LEN  (PULSE_LEN),
        .PRI_LEN    (PRI_LEN),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .play       (play),
        .num_pulses (num_pulses),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .pulse_idx  (timer_idx),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .last_pulse (last_pulse),
        .pri_end    (pri_end)
    );

    always_comb begin
        state_next = state_reg;
        flush_next = flush_reg;
        load       = 1'b0;
        advance    = 1'b0;
        zero_start = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (num_pulses != '0) begin
                            state_next = PLAY;
                            load       = 1'b1;
                        end else begin
                            zero_start = 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (last_addr && last_pulse) begin
                        state_next = FLUSH;
                        flush_next = 1'b0;
                    end else begin
                        advance = 1'b1;
                        if (last_addr && !BACK_TO_BACK)
                            state_next = GAP;
                    end
                end
                GAP: begin
                    advance = 1'b1;
                    if (pri_end)
                        state_next = PLAY;
                end
                FLUSH: begin
                    // Two cycles let the final sample drain through the pipeline.
                    if (flush_reg)
                        state_next = IDLE;
                    else
                        flush_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            flush_reg     <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_reg     <= flush_next;
            zero_done_reg <= zero_start;
        end
    end

    assign play = (state_reg == PLAY);
    assign busy = (state_reg != IDLE);

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rom_en;
        tag_in.sop   = rom_en && first_addr;
        tag_in.eop   = rom_en && last_addr;
        tag_in.last  = rom_en && last_addr && last_pulse;
        tag_in.idx   = timer_idx;
    end

    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
        tag_t stage_in;
        tag_t stage_reg;

        if (gi == 0) begin : g_head
            assign stage_in = tag_in;
        end else begin : g_tail
            assign stage_in = g_pipe[gi-1].stage_reg;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg <= '0;
            end else if (abort) begin
                stage_reg.valid <= 1'b0;
                stage_reg.sop   <= 1'b0;
                stage_reg.eop   <= 1'b0;
                stage_reg.last  <= 1'b0;
            end else begin
                stage_reg.valid <= stage_in.valid;
                stage_reg.sop   <= stage_in.sop;
                stage_reg.eop   <= stage_in.eop;
                stage_reg.last  <= stage_in.last;
                // Index holds between pulses so it always names the pulse last shown.
                if (stage_in.valid)
                    stage_reg.idx <= stage_in.idx;
            end
        end
    end

    assign tag_pre = g_pipe[PIPE_LAT-2].stage_reg;
    assign tag_out = g_pipe[PIPE_LAT-1].stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_reg <= '0;
        else if (abort || !tag_pre.valid)
            data_reg <= '0;
        else
            data_reg <= rom_data;
    end

    assign if_data_out = data_reg;
    assign if_valid    = tag_out.valid;
    assign pulse_sop   = tag_out.sop;
    assign pulse_eop   = tag_out.eop;
    assign pulse_idx   = tag_out.idx;
    assign done        = tag_out.last || zero_done_reg;

endmodule

// File: tb/tb_if_pulse_player.sv
// Bench for if_pulse_player: per-cycle scoreboard against a timing model,
// table-driven train scenarios, and hand sequences for abort/restart/reset.
module tb_if_pulse_player;

    localparam int AW = 11;
    localparam int DW = 12;
    localparam int CW = 8;
    localparam int PLEN = 8;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic          done;
        logic          busy;
        logic          ren;
        logic [AW-1:0] addr;
        logic [CW-1:0] idx;
    } cyc_t;

    typedef struct {
        int n;
        bit b2b;
        int exp_valid;
        int exp_ren;
        int exp_busy;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start_a, start_b, abort;
    logic [CW-1:0] num_pulses;

    logic a_ren, b_ren;
    logic [AW-1:0] a_addr, b_addr;
    logic signed [DW-1:0] a_rom, b_rom, a_data, b_data;
    logic a_v, b_v, a_sop, b_sop, a_eop, b_eop, a_busy, b_busy, a_done, b_done;
    logic [CW-1:0] a_idx, b_idx;

    int nerr = 0;
    int nchk = 0;
    cyc_t sb_q[$];

    always #5 clk = ~clk;

    if_pulse_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PULSE_LEN(PLEN), .PRI_LEN(12), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .num_pulses(num_pulses),
        .rom_en(a_ren), .rom_addr(a_addr), .rom_data(a_rom), .if_data_out(a_data),
        .if_valid(a_v), .pulse_sop(a_sop), .pulse_eop(a_eop), .pulse_idx(a_idx),
        .busy(a_busy), .done(a_done)
    );

    if_pulse_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PULSE_LEN(PLEN), .PRI_LEN(8), .CNT_WIDTH(CW)) dut_b2b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .num_pulses(num_pulses),
        .rom_en(b_ren), .rom_addr(b_addr), .rom_data(b_rom), .if_data_out(b_data),
        .if_valid(b_v), .pulse_sop(b_sop), .pulse_eop(b_eop), .pulse_idx(b_idx),
        .busy(b_busy), .done(b_done)
    );

    // Behavioural ROMs: one-cycle read latency, data = addr + 100.
    always @(posedge clk) begin
        if (a_ren) a_rom <= DW'(a_addr) + DW'(100);
        if (b_ren) b_rom <= DW'(b_addr) + DW'(100);
    end

    function automatic cyc_t sample(input bit b2b);
        cyc_t s;
        if (b2b) s = '{v: b_v, d: b_data, sop: b_sop, eop: b_eop, done: b_done, busy: b_busy, ren: b_ren, addr: b_addr, idx: b_idx};
        else     s = '{v: a_v, d: a_data, sop: a_sop, eop: a_eop, done: a_done, busy: a_busy, ren: a_ren, addr: a_addr, idx: a_idx};
        return s;
    endfunction

    // Expected outputs t cycles after the start edge (edge 1).
    function automatic cyc_t exp_at(input int n, input int pri, input int t, input int abort_at);
        cyc_t e;
        e = '0;
        if (abort_at > 0 && t > abort_at) return e;
        for (int p = 0; p < n; p++) begin
            for (int s = 0; s < PLEN; s++) begin
                if (t == 3 + p * pri + s) begin
                    e.v   = 1'b1;
                    e.d   = DW'(100 + s);
                    e.sop = (s == 0);
                    e.eop = (s == PLEN - 1);
                    e.idx = CW'(p);
                end
                if (t == 1 + p * pri + s) begin
                    e.ren  = 1'b1;
                    e.addr = AW'(s);
                end
            end
        end
        e.done = (n > 0) ? (t == 3 + (n - 1) * pri + PLEN - 1) : (t == 1);
        e.busy = (n > 0) && (t >= 1) && (t <= (n - 1) * pri + PLEN + 2);
        return e;
    endfunction

    task automatic chk_int(input string name, input int got, input int expv);
        nchk++;
        if (got != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic chk_cyc(input string name, input int t, input cyc_t got, input cyc_t e);
        bit bad;
        bad = (got.v != e.v) || (got.d != e.d) || (got.sop != e.sop) || (got.eop != e.eop) ||
              (got.done != e.done) || (got.busy != e.busy) || (got.ren != e.ren) ||
              (e.ren && got.addr != e.addr) || (e.v && got.idx != e.idx);
        nchk++;
        if (bad) begin
            nerr++;
            $display("FAIL %s t=%0d: got v=%0b d=%0d sop=%0b eop=%0b idx=%0d done=%0b busy=%0b ren=%0b addr=%0d; expected v=%0b d=%0d sop=%0b eop=%0b idx=%0d done=%0b busy=%0b ren=%0b addr=%0d",
                     name, t, got.v, got.d, got.sop, got.eop, got.idx, got.done, got.busy, got.ren, got.addr,
                     e.v, e.d, e.sop, e.eop, e.idx, e.done, e.busy, e.ren, e.addr);
        end
    endtask

    // Called just after a falling edge; edge 1 is the next rising edge.
    task automatic run_test(input string name, input int n, input bit b2b, input int abort_at,
                            input int restart_at, input int win,
                            output int cv, output int cr, output int cb, output int cd);
        int pri;
        cyc_t got, e;
        pri = b2b ? 8 : 12;
        cv = 0; cr = 0; cb = 0; cd = 0;
        num_pulses = CW'(n);
        if (b2b) start_b = 1'b1; else start_a = 1'b1;
        for (int t = 1; t <= win; t++) sb_q.push_back(exp_at(n, pri, t, abort_at));
        for (int t = 1; t <= win; t++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            abort   = 1'b0;
            got = sample(b2b);
            e   = sb_q.pop_front();
            chk_cyc(name, t, got, e);
            cv += int'(got.v);
            cr += int'(got.ren);
            cb += int'(got.busy);
            cd += int'(got.done);
            if (t == abort_at) abort = 1'b1;
            if (t == restart_at) begin
                num_pulses = CW'(5);
                if (b2b) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        $display("%s: n=%0d pri=%0d valid=%0d rom_en=%0d busy=%0d done=%0d", name, n, pri, cv, cr, cb, cd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int cv, cr, cb, cd;
        cyc_t zero_c;

        tbl[0] = '{n: 1, b2b: 1'b0, exp_valid: 8,  exp_ren: 8,  exp_busy: 10, exp_done: 1};
        tbl[1] = '{n: 3, b2b: 1'b0, exp_valid: 24, exp_ren: 24, exp_busy: 34, exp_done: 1};
        tbl[2] = '{n: 2, b2b: 1'b1, exp_valid: 16, exp_ren: 16, exp_busy: 18, exp_done: 1};
        tbl[3] = '{n: 0, b2b: 1'b0, exp_valid: 0,  exp_ren: 0,  exp_busy: 0,  exp_done: 1};
        tbl[4] = '{n: 2, b2b: 1'b0, exp_valid: 16, exp_ren: 16, exp_busy: 22, exp_done: 1};
        zero_c = '0;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; num_pulses = '0;
        repeat (3) @(negedge clk);
        chk_cyc("reset_a", 0, sample(1'b0), zero_c);
        chk_cyc("reset_b", 0, sample(1'b1), zero_c);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_test($sformatf("vec%0d", i), tbl[i].n, tbl[i].b2b, 0, 0, 40, cv, cr, cb, cd);
            chk_int($sformatf("vec%0d_valid_count", i), cv, tbl[i].exp_valid);
            chk_int($sformatf("vec%0d_rom_en_count", i), cr, tbl[i].exp_ren);
            chk_int($sformatf("vec%0d_busy_cycles", i), cb, tbl[i].exp_busy);
            chk_int($sformatf("vec%0d_done_count", i), cd, tbl[i].exp_done);
            repeat (2) @(negedge clk);
        end

        // Abort at PRI count 5 of pulse 1, then a clean replay.
        run_test("abort", 3, 1'b0, 18, 0, 30, cv, cr, cb, cd);
        chk_int("abort_done_count", cd, 0);
        run_test("after_abort", 1, 1'b0, 0, 0, 14, cv, cr, cb, cd);
        chk_int("after_abort_valid_count", cv, 8);

        // Start while busy is ignored and the count is not re-latched.
        run_test("restart_ignored", 2, 1'b0, 0, 5, 30, cv, cr, cb, cd);
        chk_int("restart_valid_count", cv, 16);
        repeat (2) @(negedge clk);

        // Abort together with start in IDLE: start dropped.
        num_pulses = CW'(2);
        start_a = 1'b1;
        abort = 1'b1;
        cb = 0; cr = 0; cd = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort = 1'b0;
            cb += int'(a_busy);
            cr += int'(a_ren);
            cd += int'(a_done);
        end
        chk_int("abort_start_busy", cb, 0);
        chk_int("abort_start_rom_en", cr, 0);
        chk_int("abort_start_done", cd, 0);
        $display("abort_with_start: busy=%0d rom_en=%0d done=%0d", cb, cr, cd);

        // Asynchronous reset mid-burst.
        num_pulses = CW'(2);
        start_a = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        chk_int("pre_reset_valid", int'(a_v), 1);
        #2 rst = 1'b1;
        #1;
        chk_cyc("async_reset", 6, sample(1'b0), zero_c);
        @(negedge clk);
        rst = 1'b0;
        cv = 0; cd = 0; cb = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            cv += int'(a_v);
            cd += int'(a_done);
            cb += int'(a_busy);
        end
        chk_int("post_reset_valid", cv, 0);
        chk_int("post_reset_done", cd, 0);
        chk_int("post_reset_busy", cb, 0);
        $display("reset_mid_burst: valid=%0d done=%0d busy=%0d", cv, cd, cb);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
